// File: rtl/mbox_cmd_scheduler_if.sv
// mbox_cmd_scheduler_if
// Bundles the post, mailbox RAM, SPI engine and completion signals of the
// mailbox command scheduler.
//   master : the scheduler side (drives post_err, ram_*, spi_cmd*, done_*,
//            pending, busy)
//   slave  : the environment side (drives post_*, ram_rdata, spi_cmd_ready,
//            spi_done, spi_rdata)
interface mbox_cmd_scheduler_if #(
  parameter int N_SLOTS = 16,
  parameter int ADDR_W  = 5
);
  logic              post_valid;
  logic [ADDR_W-1:0] post_slot;
  logic              post_err;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [40:0]       ram_wdata;
  logic [40:0]       ram_rdata;

  logic              spi_cmd_valid;
  logic              spi_cmd_ready;
  logic [40:0]       spi_cmd;
  logic              spi_done;
  logic [31:0]       spi_rdata;

  logic              done_valid;
  logic [ADDR_W-1:0] done_slot;
  logic              done_rd;
  logic              done_err;

  logic [N_SLOTS-1:0] pending;
  logic              busy;

  modport master (
    input  post_valid, post_slot, ram_rdata, spi_cmd_ready, spi_done, spi_rdata,
    output post_err, ram_en, ram_we, ram_addr, ram_wdata, spi_cmd_valid, spi_cmd,
           done_valid, done_slot, done_rd, done_err, pending, busy
  );

  modport slave (
    output post_valid, post_slot, ram_rdata, spi_cmd_ready, spi_done, spi_rdata,
    input  post_err, ram_en, ram_we, ram_addr, ram_wdata, spi_cmd_valid, spi_cmd,
           done_valid, done_slot, done_rd, done_err, pending, busy
  );
endinterface

// File: rtl/mbox_cmd_scheduler.sv
// mbox_cmd_scheduler
// Sequencer for the SPI command mailbox RAM. Posted slot indices set bits in
// a pending bitmap; slots are served round-robin: fetch the command word,
// offer it to the SPI engine, write read results back into the same slot and
// pulse a completion.
// Command word: [40] rd, [39:32] register address, [31:0] data.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : mbox_cmd_scheduler_if.master (post, RAM port, SPI engine,
//          completion, pending bitmap, busy)
// Optional feature macro: CMD_TIMEOUT_EN -- bounds WAIT_SPI to TIMEOUT_CYC
// cycles; an expired read writes back data 0 and completes with done_err=1.
// Without it WAIT_SPI waits indefinitely and done_err is tied to 0.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | nothing in service; picks the next pending slot
// FETCH     | RAM read of the selected slot
// CAPTURE   | RAM read data registered into cmd_q
// ISSUE     | command offered to the SPI engine until accepted
// WAIT_SPI  | read accepted, waiting for spi_done
// WRITEBACK | read result written back into the slot
// COMPLETE  | completion pulse, slot cleared, round-robin pointer advanced
module mbox_cmd_scheduler #(
  parameter int N_SLOTS     = 16,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mbox_cmd_scheduler_if.master bus
);

  if ((2 ** ADDR_W) < N_SLOTS) begin : g_bad_addr_w
    $error("ADDR_W too small for N_SLOTS");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, ISSUE, WAIT_SPI, WRITEBACK, COMPLETE
  } state_t;

  state_t             state;
  logic [N_SLOTS-1:0] pending_q;
  logic [ADDR_W-1:0]  rr_ptr;
  logic [ADDR_W-1:0]  slot_q;
  logic [40:0]        cmd_q;

  logic               post_err_q;
  logic               ram_en_q;
  logic               ram_we_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [40:0]        ram_wdata_q;
  logic               spi_valid_q;
  logic               done_valid_q;
  logic [ADDR_W-1:0]  done_slot_q;
  logic               done_rd_q;
  logic               busy_q;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0]   tmo_cnt;
  logic               tmo_q;
  logic               done_err_q;
`endif

  // Post acceptance. The slot being cleared in COMPLETE does not count as a
  // duplicate, so a repost in that cycle is accepted and its set wins.
  logic               post_in_range;
  logic               post_dup;
  logic               post_ok;
  logic [N_SLOTS-1:0] post_mask;
  logic [N_SLOTS-1:0] clr_mask;

  always_comb begin
    post_in_range = int'(bus.post_slot) < N_SLOTS;
    post_mask     = N_SLOTS'(1) << bus.post_slot;
    clr_mask      = (state == COMPLETE) ? (N_SLOTS'(1) << slot_q) : '0;
    post_dup      = |(pending_q & post_mask & ~clr_mask);
    post_ok       = bus.post_valid && post_in_range && !post_dup;
  end

  // Round-robin pick: rotate the bitmap so rr_ptr lands on bit 0, take the
  // lowest set bit, then add rr_ptr back modulo N_SLOTS.
  logic [N_SLOTS-1:0] rot;
  logic [N_SLOTS-1:0] rot_sh;
  logic [ADDR_W-1:0]  sel_slot;
  int                 sel_off;
  int                 sel_sum;

  always_comb begin
    rot     = N_SLOTS'({pending_q, pending_q} >> rr_ptr);
    rot_sh  = '0;
    sel_off = 0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      rot_sh = rot >> i;
      if (rot_sh[0]) sel_off = i;
    end
    sel_sum = int'(rr_ptr) + sel_off;
    if (sel_sum >= N_SLOTS) sel_sum = sel_sum - N_SLOTS;
    sel_slot = ADDR_W'(sel_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending_q    <= '0;
      rr_ptr       <= '0;
      slot_q       <= '0;
      cmd_q        <= '0;
      post_err_q   <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      spi_valid_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_slot_q  <= '0;
      done_rd_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt      <= '0;
      tmo_q        <= 1'b0;
      done_err_q   <= 1'b0;
`endif
    end else begin
      pending_q    <= (pending_q & ~clr_mask) | (post_ok ? post_mask : '0);
      post_err_q   <= bus.post_valid && !post_ok;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      done_valid_q <= 1'b0;
      done_slot_q  <= '0;
      done_rd_q    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      done_err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|pending_q) begin
            slot_q     <= sel_slot;
            ram_en_q   <= 1'b1;
            ram_addr_q <= sel_slot;
            busy_q     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          cmd_q       <= bus.ram_rdata;
          spi_valid_q <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (bus.spi_cmd_ready) begin
            spi_valid_q <= 1'b0;
            if (cmd_q[40]) begin
              state <= WAIT_SPI;
`ifdef CMD_TIMEOUT_EN
              tmo_cnt <= CNT_W'(TIMEOUT_CYC - 1);
              tmo_q   <= 1'b0;
`endif
            end else begin
              done_valid_q <= 1'b1;
              done_slot_q  <= slot_q;
              done_rd_q    <= 1'b0;
              state        <= COMPLETE;
            end
          end
        end
        WAIT_SPI: begin
          // spi_done on the expiry cycle wins over the timeout
          if (bus.spi_done) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= slot_q;
            ram_wdata_q <= {1'b1, cmd_q[39:32], bus.spi_rdata};
            state       <= WRITEBACK;
          end
`ifdef CMD_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= slot_q;
            ram_wdata_q <= {1'b1, cmd_q[39:32], 32'h0};
            tmo_q       <= 1'b1;
            state       <= WRITEBACK;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        WRITEBACK: begin
          done_valid_q <= 1'b1;
          done_slot_q  <= slot_q;
          done_rd_q    <= cmd_q[40];
`ifdef CMD_TIMEOUT_EN
          done_err_q   <= tmo_q;
`endif
          state        <= COMPLETE;
        end
        COMPLETE: begin
          rr_ptr <= (slot_q == ADDR_W'(N_SLOTS - 1)) ? '0 : slot_q + 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.post_err      = post_err_q;
  assign bus.ram_en        = ram_en_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;
  assign bus.spi_cmd_valid = spi_valid_q;
  assign bus.spi_cmd       = cmd_q;
  assign bus.done_valid    = done_valid_q;
  assign bus.done_slot     = done_slot_q;
  assign bus.done_rd       = done_rd_q;
  assign bus.pending       = pending_q;
  assign bus.busy          = busy_q;
`ifdef CMD_TIMEOUT_EN
  assign bus.done_err      = done_err_q;
`else
  assign bus.done_err      = 1'b0;
`endif

endmodule

// File: doc/mbox_cmd_scheduler.md
Name: mbox_cmd_scheduler

Overview:
Sequencer for the 16-slot, 41-bit SPI command mailbox RAM. The Wishbone side writes command words into slots and posts each slot's index here. The block keeps a pending bitmap and picks slots round-robin. For each slot it fetches the word, hands it to the SPI engine, writes read results back into the same slot, and reports completion. Sits on the SPI-clock side between the mailbox RAM port and the SPI master.

Parameters:
N_SLOTS, 16, number of mailbox slots
ADDR_W, 5, RAM address width; must satisfy 2**ADDR_W >= N_SLOTS
TIMEOUT_CYC, 1024, SPI response timeout in cycles; used only with CMD_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
post_valid  in  1  one-cycle pulse: a command word has been written to post_slot
post_slot  in  ADDR_W  posted slot index
post_err  out  1  one-cycle pulse: the post was rejected
ram_en  out  1  mailbox RAM port enable
ram_we  out  1  mailbox RAM write enable
ram_addr  out  ADDR_W  mailbox RAM address
ram_wdata  out  41  write-back word
ram_rdata  in  41  RAM read data; valid one cycle after ram_en with ram_we=0
spi_cmd_valid  out  1  command offered to the SPI engine
spi_cmd_ready  in  1  SPI engine accepts the command
spi_cmd  out  41  command word
spi_done  in  1  one-cycle pulse: read transaction finished
spi_rdata  in  32  read data; valid with spi_done
done_valid  out  1  one-cycle completion pulse
done_slot  out  ADDR_W  slot that completed
done_rd  out  1  the completed command was a read
done_err  out  1  completion with error; valid with done_valid
pending  out  N_SLOTS  pending-slot bitmap
busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0. State=IDLE, pending=0, rr_ptr=0.
- A reset mid-operation abandons the current command with no done pulse. spi_cmd_valid drops on the next cycle.
- Command word format: [40] rd (1=read, 0=write), [39:32] register address, [31:0] data.
- Post handling:
  - A valid post sets pending[post_slot] on the next cycle.
  - post_err pulses on the next cycle, and pending is left unchanged, if post_slot >= N_SLOTS or that slot is already pending. A slot currently in service is still pending.
  - A post to slot k in the same cycle that slot k is cleared in COMPLETE is accepted; the set wins.
- Selection: the first pending slot at index >= rr_ptr, wrapping modulo N_SLOTS. After slot k completes, rr_ptr = (k+1) mod N_SLOTS.
- States:
  - IDLE: if pending != 0, latch the selected slot and go to FETCH.
  - FETCH (1 cycle): ram_en=1, ram_we=0, ram_addr=slot. Go to CAPTURE.
  - CAPTURE (1 cycle): register ram_rdata into cmd_q. Go to ISSUE.
  - ISSUE: spi_cmd_valid=1 and spi_cmd=cmd_q, held stable until spi_cmd_ready. On the accept cycle: if rd=0 go to COMPLETE, else go to WAIT_SPI.
  - WAIT_SPI: wait for spi_done, register spi_rdata, then go to WRITEBACK. A spi_done outside WAIT_SPI is ignored.
  - WRITEBACK (1 cycle): ram_en=1, ram_we=1, ram_addr=slot, ram_wdata={1'b1, cmd_q[39:32], rdata_q}. Go to COMPLETE.
  - COMPLETE (1 cycle): done_valid=1, done_slot=slot, done_rd=cmd_q[40]. Clear pending[slot], advance rr_ptr, go to IDLE.
- Latency:
  - Post at cycle 0 with the block idle: FETCH at cycle 2, spi_cmd_valid from cycle 4.
  - Write command accepted at cycle A: done_valid at A+1.
  - Read with spi_done at cycle D: RAM write at D+1, done_valid at D+2.
- ram_en and ram_we are 0 outside FETCH and WRITEBACK.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_SPI. If spi_done has not arrived after TIMEOUT_CYC cycles, go to WRITEBACK with data field 32'h0.
  - In the following COMPLETE, done_err=1.
  - A spi_done arriving on the expiry cycle takes priority over the timeout: normal data, done_err=0.
- Not defined: WAIT_SPI waits indefinitely, no counter logic is built, and done_err is tied to 0.

Test Plan:
- Reset: assert rst 3 cycles mid-read (in WAIT_SPI) -> all outputs 0, pending=0, busy=0, no done_valid; next post to slot 0 starts fetch from slot 0.
- Write: RAM[3]={0,8'h12,32'hA5A5_0001}, post slot 3, spi_cmd_ready low 3 cycles -> spi_cmd stable with that value while waiting; one cycle after accept done_valid=1, done_slot=3, done_rd=0, pending[3]=0; no RAM write.
- Read: RAM[5]={1,8'h40,32'h0}, post slot 5, spi_done 10 cycles after accept with spi_rdata=32'hCAFE_F00D -> ram_we=1 at addr 5 with wdata={1,8'h40,32'hCAFE_F00D}; done_valid one cycle later with done_rd=1, done_err=0.
- Round-robin: post 2, 7, 14 while busy; repost 2 after it completes -> service order 2, 7, 14, 2.
- Post errors: post slot 7 while it is pending -> post_err pulse, slot served once; post slot 16 -> post_err, pending unchanged.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYC=16): read with no spi_done -> after 16 cycles RAM write data field 0, done_valid=1 with done_err=1; spi_done on the expiry cycle -> done_err=0.
